// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with registered read data and registered status flags.
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          write_en,
  input  logic                          read_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_nxt;
  logic [AW:0] rd_ptr_nxt;
  logic [AW:0] count_nxt;
  logic        empty_nxt;
  logic        full_nxt;
  logic        wr_acc;
  logic        rd_acc;

  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_acc) wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, 1'b1};
    if (rd_acc) rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, 1'b1};
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + {{AW{1'b0}}, 1'b1};
      2'b01:   count_nxt = count - {{AW{1'b0}}, 1'b1};
      default: count_nxt = count;
    endcase
    // Flags are derived from the next pointers so they are registered alongside them.
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      empty  <= empty_nxt;
      full   <= full_nxt;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr[AW-1:0]];
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full) overflow  <= 1'b1;
      if (read_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based reference model.
// Checks the sticky error outputs as well when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic          empty;
  logic          full;
  logic [2:0]    count;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] m_dout = '0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"}, 64'(data_out), 64'(m_dout));
    chk({tag, ".empty"},    64'(empty),    64'(q.size() == 0));
    chk({tag, ".full"},     64'(full),     64'(q.size() == D));
    chk({tag, ".count"},    64'(count),    64'(q.size()));
`ifdef SYNC_FIFO_ERR_EN
    chk({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
    chk({tag, ".underflow"}, 64'(underflow), 64'(m_udf));
`endif
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare after the edge.
  task automatic step(input string tag, input bit we, input bit re, input logic [W-1:0] d);
    bit wacc;
    bit racc;
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge clk);
    wacc = we && (q.size() < D);
    racc = re && (q.size() > 0);
    if (we && q.size() == D) m_ovf = 1'b1;
    if (re && q.size() == 0) m_udf = 1'b1;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  initial begin
    // Reset held, then idle
    #12;
    check_all("reset");
    @(negedge clk);
    rstN = 1'b1;
    step("idle", 1'b0, 1'b0, '0);
    step("idle", 1'b0, 1'b0, '0);

    // Ordered fill and drain
    step("wr1", 1'b1, 1'b0, 32'h11);
    step("wr2", 1'b1, 1'b0, 32'h22);
    step("wr3", 1'b1, 1'b0, 32'h33);
    step("wr4", 1'b1, 1'b0, 32'h44);
    chk("full_after_4", 64'(full), 64'd1);
    for (int i = 0; i < 4; i++) step("rd", 1'b0, 1'b1, '0);
    chk("dout_last", 64'(data_out), 64'h44);

    // Overflow attempt
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, $urandom);
    step("ovf", 1'b1, 1'b0, 32'hDEAD);
    step("ovf_hold", 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, '0);

    // Underflow attempt
    step("udf", 1'b0, 1'b1, '0);
    step("udf_hold", 1'b0, 1'b0, '0);

    // Simultaneous read/write at steady occupancy, crossing pointer wrap
    step("pre", 1'b1, 1'b0, $urandom);
    step("pre", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 10; i++) step("pair", 1'b1, 1'b1, $urandom);
    chk("pair_count", 64'(count), 64'd2);
    step("drain", 1'b0, 1'b1, '0);
    step("drain", 1'b0, 1'b1, '0);
    step("both_empty", 1'b1, 1'b1, 32'hA5A5_0001);
    chk("both_empty_count", 64'(count), 64'd1);
    for (int i = 0; i < 3; i++) step("fill", 1'b1, 1'b0, $urandom);
    step("both_full", 1'b1, 1'b1, 32'hBAD0_BAD0);
    chk("both_full_count", 64'(count), 64'd3);

    // Asynchronous reset mid-burst
    write_en = 1'b1;
    read_en  = 1'b0;
    data_in  = 32'h1234_5678;
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    write_en = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    step("rd_after_rst", 1'b0, 1'b1, '0);

    // Randomized traffic with varying bias
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step("rand", ($urandom_range(99) < bias), ($urandom_range(99) < 100 - bias + 10), $urandom);
    end

    write_en = 1'b0;
    read_en  = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
